// File: rtl/ascon_pack.sv
// rtl/ascon_pack.sv - shared Ascon types, constants and round-constant helper
package ascon_pack;

    // Round index width: rounds 0..11 fit in four bits.
    localparam int RND_WIDTH = 4;

    localparam logic [RND_WIDTH-1:0] LastRound = RND_WIDTH'(11);
    localparam logic [3:0]           RcBase    = 4'hF;

    typedef enum logic [1:0] {
        PERM_IDLE = 2'd0,
        PERM_RUN  = 2'd1,
        PERM_LAST = 2'd2,
        PERM_DONE = 2'd3
    } perm_ctrl_state_e;

    // Ascon round constant: upper nibble counts down from F while the
    // lower nibble counts up with the round index.
    function automatic logic [7:0] round_const(input logic [RND_WIDTH-1:0] round);
        logic [3:0] r;
        r = round[3:0];
        return {RcBase - r, r};
    endfunction

endpackage

// File: rtl/ascon_perm_ctrl.sv
// rtl/ascon_perm_ctrl.sv - Ascon permutation sequencing controller
//
// Drives the external round counter (load/enable/select), presents the round
// constant and datapath enable each round, and holds done_o until acked.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   start_i, p12_i     permutation request and round count (1 = p12, 0 = p6)
//   stall_i            freeze the in-flight permutation this cycle
//   done_ack_i         acknowledge for done_o
//   round_i            current round index from the counter
//   n_last_rnd_i       counter is at round 10 (next round is the last)
//   cnt_load_o         load counter start value
//   cnt_en_o           counter register enable
//   cnt_sel_p12_o      counter start select (1 -> 0, 0 -> 6)
//   perm_en_o          apply one round to the state this cycle
//   rc_o               round constant for the current round
//   ready_o            idle, start_i accepted
//   done_o             permutation finished, held until acked
//   err_o              sticky protocol error
module ascon_perm_ctrl
    import ascon_pack::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 p12_i,
    input  logic                 stall_i,
    input  logic                 done_ack_i,
    input  logic [RND_WIDTH-1:0] round_i,
    input  logic                 n_last_rnd_i,
    output logic                 cnt_load_o,
    output logic                 cnt_en_o,
    output logic                 cnt_sel_p12_o,
    output logic                 perm_en_o,
    output logic [7:0]           rc_o,
    output logic                 ready_o,
    output logic                 done_o,
    output logic                 err_o
);

    perm_ctrl_state_e state_q, state_d;
    logic             err_set;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= PERM_IDLE;
            err_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (err_set) begin
                err_o <= 1'b1;
            end
        end
    end

    // Counter controls depend only on state, start_i, p12_i and stall_i;
    // round_i only feeds rc_o, the error check and the next state.
    always_comb begin
        state_d       = state_q;
        err_set       = 1'b0;
        cnt_load_o    = 1'b0;
        cnt_en_o      = 1'b0;
        cnt_sel_p12_o = 1'b0;
        perm_en_o     = 1'b0;
        rc_o          = 8'h00;
        ready_o       = 1'b0;
        done_o        = 1'b0;

        case (state_q)
            PERM_IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    cnt_load_o    = 1'b1;
                    cnt_en_o      = 1'b1;
                    cnt_sel_p12_o = p12_i;
                    state_d       = PERM_RUN;
                end
            end
            PERM_RUN: begin
                rc_o = round_const(round_i);
                if (!stall_i) begin
                    perm_en_o = 1'b1;
                    cnt_en_o  = 1'b1;
                    if (n_last_rnd_i) begin
                        state_d = PERM_LAST;
                    end
                end
                // Reaching round 11 (or beyond) without the round-10 hint
                // means the counter and controller disagree; finish anyway.
                if (round_i >= LastRound) begin
                    err_set = 1'b1;
                    state_d = PERM_DONE;
                end
            end
            PERM_LAST: begin
                rc_o = round_const(LastRound);
                if (!stall_i) begin
                    perm_en_o = 1'b1;
                    // Counter saturates at 11, so enabling it here is benign.
                    cnt_en_o  = 1'b1;
                    state_d   = PERM_DONE;
                end
                if (round_i > LastRound) begin
                    err_set = 1'b1;
                    state_d = PERM_DONE;
                end
            end
            PERM_DONE: begin
                done_o = 1'b1;
                if (done_ack_i) begin
                    state_d = PERM_IDLE;
                end
            end
            default: begin
                state_d = PERM_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// tb/tb_ascon_perm_ctrl.sv - self-checking bench for ascon_perm_ctrl
module tb_ascon_perm_ctrl;
    import ascon_pack::*;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b0;
    logic                 start_i = 1'b0;
    logic                 p12_i = 1'b0;
    logic                 stall_i = 1'b0;
    logic                 done_ack_i = 1'b0;
    logic [RND_WIDTH-1:0] round_i;
    logic                 n_last_rnd_i;
    logic                 cnt_load_o;
    logic                 cnt_en_o;
    logic                 cnt_sel_p12_o;
    logic                 perm_en_o;
    logic [7:0]           rc_o;
    logic                 ready_o;
    logic                 done_o;
    logic                 err_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Round counter model: loads 0 (p12) or 6 (p6), saturates at 11.
    logic [3:0] cnt = 4'd0;
    logic       force_en = 1'b0;
    logic [3:0] force_val = 4'd0;

    assign round_i      = force_en ? force_val : cnt;
    assign n_last_rnd_i = !force_en && (cnt == 4'd10);

    always @(posedge clk_i) begin
        if (cnt_en_o) begin
            if (cnt_load_o)       cnt <= cnt_sel_p12_o ? 4'd0 : 4'd6;
            else if (cnt < 4'd11) cnt <= cnt + 4'd1;
        end
    end

    always #5 clk_i = ~clk_i;

    ascon_perm_ctrl dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .p12_i         (p12_i),
        .stall_i       (stall_i),
        .done_ack_i    (done_ack_i),
        .round_i       (round_i),
        .n_last_rnd_i  (n_last_rnd_i),
        .cnt_load_o    (cnt_load_o),
        .cnt_en_o      (cnt_en_o),
        .cnt_sel_p12_o (cnt_sel_p12_o),
        .perm_en_o     (perm_en_o),
        .rc_o          (rc_o),
        .ready_o       (ready_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    logic [7:0] rc_tbl [12];
    initial begin
        rc_tbl[0]  = 8'hF0; rc_tbl[1]  = 8'hE1; rc_tbl[2]  = 8'hD2; rc_tbl[3]  = 8'hC3;
        rc_tbl[4]  = 8'hB4; rc_tbl[5]  = 8'hA5; rc_tbl[6]  = 8'h96; rc_tbl[7]  = 8'h87;
        rc_tbl[8]  = 8'h78; rc_tbl[9]  = 8'h69; rc_tbl[10] = 8'h5A; rc_tbl[11] = 8'h4B;
    end

    // Advance to just after the next rising edge; inputs are then set and
    // outputs sampled 1 time unit later, well clear of both edges.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        #1;
        n_checks++;
        if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready_o); end
        n_checks++;
        if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_o); end
        n_checks++;
        if ({done_o, perm_en_o, cnt_load_o, cnt_en_o, cnt_sel_p12_o} !== 5'b0) begin
            n_fail++; $display("FAIL reset_outs: got %b want 00000",
                               {done_o, perm_en_o, cnt_load_o, cnt_en_o, cnt_sel_p12_o});
        end
        n_checks++;
        if (rc_o !== 8'h00) begin n_fail++; $display("FAIL reset_rc: got %h want 00", rc_o); end
    endtask

    task automatic test_p12();
        int perm_cnt;
        step();
        start_i = 1'b1; p12_i = 1'b1;
        #1;
        n_checks++;
        if ({cnt_load_o, cnt_en_o, cnt_sel_p12_o} !== 3'b111) begin
            n_fail++; $display("FAIL p12_load: got %b want 111", {cnt_load_o, cnt_en_o, cnt_sel_p12_o});
        end
        perm_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            start_i = 1'b0;
            #1;
            n_checks++;
            if (rc_o !== rc_tbl[i]) begin n_fail++; $display("FAIL p12_rc[%0d]: got %h want %h", i, rc_o, rc_tbl[i]); end
            n_checks++;
            if (done_o !== 1'b0) begin n_fail++; $display("FAIL p12_early_done[%0d]: got %b want 0", i, done_o); end
            if (perm_en_o === 1'b1) perm_cnt++;
        end
        step();
        #1;
        n_checks++;
        if (perm_en_o === 1'b1) perm_cnt++;
        if (perm_cnt !== 12) begin n_fail++; $display("FAIL p12_perm_en_count: got %0d want 12", perm_cnt); end
        n_checks++;
        if (done_o !== 1'b1) begin n_fail++; $display("FAIL p12_done_T13: got %b want 1", done_o); end
        done_ack_i = 1'b1;
        step();
        done_ack_i = 1'b0;
        #1;
        n_checks++;
        if ({done_o, ready_o} !== 2'b01) begin n_fail++; $display("FAIL p12_ack: got done,ready=%b want 01", {done_o, ready_o}); end
    endtask

    task automatic test_p6();
        step();
        start_i = 1'b1; p12_i = 1'b0;
        #1;
        n_checks++;
        if ({cnt_load_o, cnt_sel_p12_o} !== 2'b10) begin
            n_fail++; $display("FAIL p6_load: got load,sel=%b want 10", {cnt_load_o, cnt_sel_p12_o});
        end
        for (int i = 0; i < 6; i++) begin
            step();
            start_i = 1'b0;
            #1;
            n_checks++;
            if (rc_o !== rc_tbl[6+i] || perm_en_o !== 1'b1) begin
                n_fail++; $display("FAIL p6_rc[%0d]: got rc=%h en=%b want rc=%h en=1", i, rc_o, perm_en_o, rc_tbl[6+i]);
            end
        end
        step();
        #1;
        n_checks++;
        if (done_o !== 1'b1 || perm_en_o !== 1'b0) begin
            n_fail++; $display("FAIL p6_done_T7: got done=%b en=%b want done=1 en=0", done_o, perm_en_o);
        end
        done_ack_i = 1'b1;
        step();
        done_ack_i = 1'b0;
    endtask

    task automatic test_stall();
        int idx;
        step();
        start_i = 1'b1; p12_i = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            step();
            start_i = 1'b0;
            stall_i = (c == 4 || c == 5);
            idx = (c <= 3) ? c - 1 : (c <= 5) ? 3 : c - 3;
            #1;
            n_checks++;
            if (rc_o !== rc_tbl[idx]) begin n_fail++; $display("FAIL stall_rc[c%0d]: got %h want %h", c, rc_o, rc_tbl[idx]); end
            n_checks++;
            if (perm_en_o !== !stall_i || cnt_en_o !== !stall_i) begin
                n_fail++; $display("FAIL stall_en[c%0d]: got perm=%b cnt=%b want %b", c, perm_en_o, cnt_en_o, !stall_i);
            end
        end
        stall_i = 1'b0;
        step();
        #1;
        n_checks++;
        if (done_o !== 1'b1) begin n_fail++; $display("FAIL stall_done_T15: got %b want 1", done_o); end
        done_ack_i = 1'b1;
        step();
        done_ack_i = 1'b0;
    endtask

    task automatic test_handshake();
        int lat;
        test_p6_to_done();
        for (int i = 0; i < 5; i++) begin
            step();
            start_i = i[0];
            stall_i = 1'b1;
            #1;
            n_checks++;
            if ({done_o, ready_o, cnt_load_o} !== 3'b100) begin
                n_fail++; $display("FAIL hs_hold[%0d]: got done,ready,load=%b want 100", i, {done_o, ready_o, cnt_load_o});
            end
        end
        start_i = 1'b0; stall_i = 1'b0;
        done_ack_i = 1'b1;
        step();
        done_ack_i = 1'b0;
        #1;
        n_checks++;
        if ({done_o, ready_o} !== 2'b01) begin n_fail++; $display("FAIL hs_ack: got done,ready=%b want 01", {done_o, ready_o}); end
        // Back-to-back: start in the very IDLE cycle after the ack.
        start_i = 1'b1; p12_i = 1'b0;
        lat = 0;
        step();
        start_i = 1'b0;
        lat = 1;
        while (done_o !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        #1;
        n_checks++;
        if (lat !== 7) begin n_fail++; $display("FAIL hs_b2b_latency: got %0d want 7", lat); end
        done_ack_i = 1'b1;
        step();
        done_ack_i = 1'b0;
    endtask

    task automatic test_p6_to_done();
        step();
        start_i = 1'b1; p12_i = 1'b0;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic test_reset_mid();
        bit seen_done;
        step();
        start_i = 1'b1; p12_i = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            step();
            start_i = 1'b0;
        end
        rst_i = 1'b1;
        #1;
        n_checks++;
        if (rc_o !== 8'h78) begin n_fail++; $display("FAIL rstmid_round8: got %h want 78", rc_o); end
        step();
        rst_i = 1'b0;
        #1;
        n_checks++;
        if ({ready_o, done_o, rc_o} !== {2'b10, 8'h00}) begin
            n_fail++; $display("FAIL rstmid_idle: got ready=%b done=%b rc=%h want 1 0 00", ready_o, done_o, rc_o);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done_o === 1'b1) seen_done = 1'b1;
        end
        n_checks++;
        if (seen_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_done: got %b want 0", seen_done); end
    endtask

    task automatic test_error();
        step();
        start_i = 1'b1; p12_i = 1'b1;
        step();
        start_i = 1'b0;
        force_en = 1'b1; force_val = 4'd11;
        #1;
        n_checks++;
        if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_not_yet: got %b want 0", err_o); end
        step();
        force_en = 1'b0;
        #1;
        n_checks++;
        if ({err_o, done_o} !== 2'b11) begin n_fail++; $display("FAIL err_set_done: got err,done=%b want 11", {err_o, done_o}); end
        done_ack_i = 1'b1;
        step();
        done_ack_i = 1'b0;
        step();
        #1;
        n_checks++;
        if ({err_o, ready_o} !== 2'b11) begin n_fail++; $display("FAIL err_sticky: got err,ready=%b want 11", {err_o, ready_o}); end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        #1;
        n_checks++;
        if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", err_o); end
    endtask

    initial begin
        test_reset();
        test_p12();
        test_p6();
        test_stall();
        test_handshake();
        test_reset_mid();
        test_error();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ascon_perm_ctrl.md
# ascon_perm_ctrl

Sequencing controller for the Ascon permutation: it sits on the driving side of the round counter interface (load/enable/select in, round/next-is-last back). It accepts a start request for p12 or p6 from the mode FSM and steps the counter one round per cycle. Each cycle it presents the round constant and datapath enable to the permutation datapath. On completion it holds a done handshake until the mode FSM acknowledges it.

## Interface
Parameters:
- None. `RND_WIDTH` comes from `ascon_pack`.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; one clock; reset is synchronous and active-high.
- `start_i` in 1: permutation request; accepted only when `ready_o`=1.
- `p12_i` in 1: round count for the request (1 = p12, 0 = p6); sampled with `start_i`.
- `stall_i` in 1: freeze the in-flight permutation for this cycle.
- `done_ack_i` in 1: acknowledges `done_o`.
- `round_i` in `RND_WIDTH`: current round index from the counter.
- `n_last_rnd_i` in 1: counter reports that the current round is 10, so the next round is the last.
- `cnt_load_o` out 1: load the counter's start value.
- `cnt_en_o` out 1: counter register enable.
- `cnt_sel_p12_o` out 1: start-value select (1 → 0, 0 → 6).
- `perm_en_o` out 1: apply one round to the state register this cycle.
- `rc_o` out 8: round constant for the current round.
- `ready_o` out 1: idle and able to accept `start_i`.
- `done_o` out 1: permutation finished; held until acknowledged.
- `err_o` out 1: sticky protocol error.

## Operation
States are IDLE, RUN, LAST and DONE.

- **IDLE**
  - `ready_o`=1.
  - On `start_i`, drive `cnt_load_o`=1, `cnt_en_o`=1 and `cnt_sel_p12_o`=`p12_i`, then go to RUN.
  - `perm_en_o`=0 in this state.
- **RUN**
  - `perm_en_o`=1 and `cnt_en_o`=1, unless `stall_i` is high; a stall holds everything.
  - `rc_o` = {4'hF − `round_i`[3:0], `round_i`[3:0]}.
  - If `n_last_rnd_i`=1 and there is no stall, go to LAST.
- **LAST**
  - Same outputs as RUN; this is round 11, so `rc_o`=0x4B.
  - With no stall, go to DONE.
  - `cnt_en_o`=1 is harmless here because the counter saturates.
- **DONE**
  - `done_o`=1, `perm_en_o`=0, `cnt_en_o`=0.
  - On `done_ack_i`, go to IDLE.
  - `start_i` is ignored here because `ready_o`=0.

Outputs outside RUN/LAST:
- `rc_o`=0.
- `cnt_load_o` is high only in the IDLE cycle that accepts a start.

Protocol error:
- `err_o` is set if `round_i`=11 while in RUN, meaning the last round arrived without a preceding `n_last_rnd_i`.
- It is also set if `round_i` > 11 in RUN or LAST.
- It stays set until `rst_i`. The FSM still completes the permutation: on the error it goes to DONE.

Other boundary rules:
- `stall_i` in IDLE or DONE has no effect.
- `start_i` in RUN, LAST or DONE is ignored and is not queued.
- On `done_ack_i` without `done_o`, nothing happens.

## Timing
- Reset (`rst_i` high at a clock edge):
  - Next cycle: state IDLE, `ready_o`=1, `err_o`=0; every other output is 0.
  - Mid-permutation reset abandons the operation, with no `done_o`. The counter is left as-is; the next start reloads it.
- Start accepted at cycle T:
  - The counter holds its start value at T+1.
  - Rounds run at T+1 … T+12 for p12, and at T+1 … T+6 for p6.
  - `done_o` rises at T+13 for p12 and at T+7 for p6.
  - Each stall cycle adds exactly one cycle.
- `done_o` deasserts the cycle after `done_ack_i` is sampled high.
  - `ready_o` is 1 in that same cycle, so back-to-back permutations cost one IDLE cycle.
- All outputs are combinational from the state register and inputs. There is no combinational path from `round_i` to `cnt_*_o`.

## Structure
- Add to `ascon_pack`:
  - the state enum type `perm_ctrl_state_e`;
  - constants `LastRound`=11 and `RcBase`=4'hF;
  - function `round_const(round)` returning 8 bits.
- Single module. The round counter stays a separate instance wired at the core level; no sub-module is instantiated here.
- One registered state and one registered `err_o`. All other logic is combinational.

## Test plan
- p12: `start_i`=1, `p12_i`=1 at T → `rc_o` sequence F0, E1, D2, C3, B4, A5, 96, 87, 78, 69, 5A, 4B over T+1..T+12; `perm_en_o` high for exactly 12 cycles; `done_o` at T+13.
- p6: `start_i`=1, `p12_i`=0 → `rc_o` sequence 96, 87, 78, 69, 5A, 4B; `done_o` at T+7; `cnt_sel_p12_o`=0 during the load cycle.
- Stall: `stall_i` high for 2 cycles while `round_i`=3 → `rc_o` holds C3, `perm_en_o`=0 and `cnt_en_o`=0 for those 2 cycles; `done_o` at T+15.
- Handshake: hold `done_ack_i`=0 for 5 cycles → `done_o` stays 1 and `start_i` pulses are ignored; ack → IDLE next cycle; a new start completes normally.
- Reset at round 8 of p12: next cycle `ready_o`=1, `done_o`=0 and `rc_o`=0; no `done_o` follows.
- Error: force `round_i`=11 in the first RUN cycle with `n_last_rnd_i`=0 → `err_o`=1 and persists; `done_o` follows; `err_o` clears only on `rst_i`.
